// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: register slice with a valid/ready handshake on both sides.
// It holds up to two words: a main register that drives the output and a
// skid register that catches the one word accepted while the downstream
// stage stalls. All outputs come straight from flops, so no input reaches
// an output combinationally. Latency is one cycle and a full-rate stream
// passes through with no bubbles.
module pipe_skid_reg #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    // Occupancy state. ONE means only the main register is live, and FULL
    // means the skid register holds the younger word as well.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   main_q,  main_d;
    logic [WIDTH-1:0]   skid_q,  skid_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q,  in_ready_d;
    logic [1:0]         count_q,     count_d;

    logic               accept;
    logic               emit;

    // Handshakes, both judged from the registered flags this slice drives.
    assign accept = in_valid  & in_ready_q;
    assign emit   = out_valid_q & out_ready;

    // Next-state, datapath and registered-output decode.
    always_comb begin
        // NOTE: every variable gets a default first, so no path through the
        // case below can leave one unassigned and infer a latch.
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = ONE;
                    main_d  = in_data;
                end
            end
            ONE: begin
                if (accept && emit) begin
                    // The word being emitted leaves, so the new one goes
                    // straight into the main register.
                    main_d = in_data;
                end else if (accept) begin
                    state_d = FULL;
                    skid_d  = in_data;
                end else if (emit) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // in_ready is low here, so only the emit side can move.
                if (emit) begin
                    state_d = ONE;
                    main_d  = skid_q;
                end
            end
            default: begin
                // Unused encoding: recover to a clean empty slice.
                state_d = EMPTY;
                main_d  = RESET_VAL;
                skid_d  = RESET_VAL;
            end
        endcase

        // Flush drops everything held and anything offered this cycle.
        if (flush) begin
            state_d = EMPTY;
            main_d  = RESET_VAL;
            skid_d  = RESET_VAL;
        end

        // Output flags are decoded from the next state so they can be
        // registered and the ports stay flop-driven.
        out_valid_d = (state_d != EMPTY);
        in_ready_d  = (state_d != FULL);
        unique case (state_d)
            ONE:     count_d = 2'd1;
            FULL:    count_d = 2'd2;
            default: count_d = 2'd0;
        endcase
    end

    // State, data and output-flag registers with synchronous reset.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            state_q     <= EMPTY;
            // NOTE: the data registers are reset on purpose: the idle output
            // must read RESET_VAL, so they are not left uninitialised.
            main_q      <= RESET_VAL;
            skid_q      <= RESET_VAL;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            count_q     <= 2'd0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            count_q     <= count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign in_ready  = in_ready_q;
    assign count     = count_q;
    assign out_data  = main_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg. It runs directed scenarios and then a random
// handshake run against a queue model of the slice. A separate scoreboard
// matches every observed emission against the words seen accepted.
module tb_pipe_skid_reg;

    localparam int           W  = 32;
    localparam logic [W-1:0] RV = 32'hDEADBEEF;

    logic         CLK = 1'b0;
    logic         reset, flush;
    logic         in_valid, in_ready;
    logic [W-1:0] in_data;
    logic         out_valid, out_ready;
    logic [W-1:0] out_data;
    logic [1:0]   count;

    pipe_skid_reg #(.WIDTH(W), .RESET_VAL(RV)) dut (
        .CLK       (CLK),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    always #5 CLK = ~CLK;

    int vectors     = 0;
    int miscompares = 0;

    // Model: FIFO contents of at most two words plus the value the output
    // register shows (it keeps the last front word after draining).
    logic [W-1:0] mq[$];
    logic [W-1:0] shown = RV;
    // Scoreboard of words observed accepted but not yet observed emitted.
    logic [W-1:0] sb[$];

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Apply the current inputs across one rising edge, advance the model,
    // then check every output 1 time unit after the edge.
    task automatic step(input string tag);
        logic         stall;
        logic [W-1:0] pre_front;
        logic         pre_dut_valid, pre_dut_ready;
        logic [W-1:0] pre_dut_data;
        logic         do_emit, do_accept;
        logic [W-1:0] sb_word;

        stall         = (mq.size() > 0) && !out_ready;
        pre_front     = (mq.size() > 0) ? mq[0] : shown;
        pre_dut_valid = out_valid;
        pre_dut_ready = in_ready;
        pre_dut_data  = out_data;

        @(posedge CLK);

        if (reset || flush) begin
            mq.delete();
            shown = RV;
            sb.delete();
        end else begin
            do_emit   = (mq.size() > 0) && out_ready;
            do_accept = in_valid && (mq.size() < 2);
            if (do_emit)   void'(mq.pop_front());
            if (do_accept) mq.push_back(in_data);
            if (mq.size() > 0) shown = mq[0];

            if (pre_dut_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check({tag, "/sb_underflow"}, pre_dut_data, ~pre_dut_data);
                end else begin
                    sb_word = sb.pop_front();
                    check({tag, "/order"}, pre_dut_data, sb_word);
                end
            end
            if (in_valid && pre_dut_ready) sb.push_back(in_data);
        end

        #1;
        check({tag, "/out_valid"}, W'(out_valid), W'(mq.size() > 0));
        check({tag, "/in_ready"},  W'(in_ready),  W'(mq.size() < 2));
        check({tag, "/count"},     W'(count),     W'(mq.size()));
        check({tag, "/out_data"},  out_data,      shown);
        if (stall && !reset && !flush) begin
            check({tag, "/stable_data"},  out_data,      pre_front);
            check({tag, "/stable_valid"}, W'(out_valid), W'(1));
        end
    endtask

    task automatic drive(input logic v, input logic [W-1:0] d, input logic r);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        drive(1'b0, '0, 1'b0);

        // Reset held two cycles, then idle.
        step("reset0");
        step("reset1");
        reset = 1'b0;
        step("idle0");
        step("idle1");

        // Streaming at full rate.
        drive(1'b1, 32'h11, 1'b1); step("stream11");
        drive(1'b1, 32'h22, 1'b1); step("stream22");
        drive(1'b1, 32'h33, 1'b1); step("stream33");
        drive(1'b0, '0,     1'b1); step("stream_drain");

        // Backpressure: fill to FULL, offer a third word, then drain.
        drive(1'b1, 32'hA1, 1'b0); step("bp_a1");
        drive(1'b1, 32'hA2, 1'b0); step("bp_a2");
        drive(1'b1, 32'hA3, 1'b0); step("bp_a3_refused");
        drive(1'b1, 32'hA3, 1'b1); step("bp_emit_a1");
        drive(1'b1, 32'hA3, 1'b1); step("bp_emit_a2");
        drive(1'b0, '0,     1'b1); step("bp_emit_a3");
        drive(1'b0, '0,     1'b1); step("bp_empty");

        // Flush while FULL, with a word offered in the flush cycle.
        drive(1'b1, 32'h5A, 1'b0); step("fl_5a");
        drive(1'b1, 32'h5B, 1'b0); step("fl_5b");
        flush = 1'b1;
        drive(1'b1, 32'h77, 1'b0); step("fl_flush");
        flush = 1'b0;
        drive(1'b0, '0, 1'b1);
        for (int i = 0; i < 3; i++) step("fl_after");

        // Reset and flush together while FULL.
        drive(1'b1, 32'hC1, 1'b0); step("rf_c1");
        drive(1'b1, 32'hC2, 1'b0); step("rf_c2");
        reset = 1'b1;
        flush = 1'b1;
        drive(1'b0, '0, 1'b1); step("rf_both");
        reset = 1'b0;
        flush = 1'b0;
        for (int i = 0; i < 3; i++) step("rf_after");

        // Random handshake with rare flushes and resets.
        for (int i = 0; i < 1000; i++) begin
            in_valid  = ($urandom % 4) != 0;
            in_data   = $urandom;
            out_ready = ($urandom % 3) != 0;
            flush     = ($urandom % 64) == 0;
            reset     = ($urandom % 250) == 0;
            step("rand");
            check("rand/count_le2", W'(count <= 2'd2), W'(1));
        end
        reset = 1'b0;
        flush = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
